// File: rtl/conv_pkg.sv
// Shared types, default widths and helper functions for the parametrised convolution engine.
package conv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDrain,
    StWrite,
    StDone
  } state_e;

  localparam int unsigned DefPixW   = 9;
  localparam int unsigned DefWgtW   = 8;
  localparam int unsigned DefOutW   = 20;
  localparam int unsigned DefImgW   = 4;
  localparam int unsigned DefImgH   = 4;
  localparam int unsigned DefK      = 3;
  localparam int unsigned DefChIn   = 1;
  localparam int unsigned DefPaddrW = 10;
  localparam int unsigned DefWaddrW = 10;
  localparam int unsigned DefOaddrW = 10;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Counter width: a count of 1 still needs one bit to hold zero.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (clog2(n) == 0) ? 1 : clog2(n);
  endfunction

  // Optional ReLU followed by clamping to a signed out_w-bit range.
  function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v,
                                                  input int unsigned out_w,
                                                  input logic relu);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    r  = (relu && (v < 64'sd0)) ? 64'sd0 : v;
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate with clear/enable; result passes through ReLU and saturation.
module conv_mac
  import conv_pkg::*;
#(
  parameter int unsigned PIX_W = DefPixW,
  parameter int unsigned WGT_W = DefWgtW,
  parameter int unsigned ACC_W = 22,
  parameter int unsigned OUT_W = DefOutW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [PIX_W-1:0] pixel,
  input  logic [WGT_W-1:0] weight,
  input  logic             relu,
  output logic [OUT_W-1:0] result
);

  localparam int unsigned ProdW = PIX_W + 1 + WGT_W;

  logic signed [ProdW-1:0] prod;
  logic signed [ACC_W-1:0] acc_q;

  always_comb begin
    // Pixel is unsigned: zero-extend by one bit before the signed multiply.
    prod   = ProdW'($signed({1'b0, pixel})) * ProdW'($signed(weight));
    result = OUT_W'(sat_relu(64'(acc_q), OUT_W, relu));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_q + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/conv_engine_param.sv
// KxK valid convolution over CH_IN channels: SRAM fetch sequencing, MAC pipeline, result write-back.
module conv_engine_param
  import conv_pkg::*;
#(
  parameter int unsigned PIX_W   = DefPixW,
  parameter int unsigned WGT_W   = DefWgtW,
  parameter int unsigned OUT_W   = DefOutW,
  parameter int unsigned IMG_W   = DefImgW,
  parameter int unsigned IMG_H   = DefImgH,
  parameter int unsigned K       = DefK,
  parameter int unsigned CH_IN   = DefChIn,
  parameter int unsigned PADDR_W = DefPaddrW,
  parameter int unsigned WADDR_W = DefWaddrW,
  parameter int unsigned OADDR_W = DefOaddrW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               relu_en,
  output logic               busy,
  output logic               finish,
  output logic               pixel_req,
  output logic [PADDR_W-1:0] pixel_addr,
  input  logic [PIX_W-1:0]   pixel,
  output logic               weight_req,
  output logic [WADDR_W-1:0] weight_addr,
  input  logic [WGT_W-1:0]   weight,
  output logic               output_req,
  output logic [OADDR_W-1:0] output_addr,
  output logic [OUT_W-1:0]   output_data
);

  localparam int unsigned OutX = IMG_W - K + 1;
  localparam int unsigned OutY = IMG_H - K + 1;
  localparam int unsigned Taps = K * K * CH_IN;
  localparam int unsigned AccW = PIX_W + WGT_W + 1 + clog2(Taps);
  localparam int unsigned KW   = cnt_w(K);
  localparam int unsigned CW   = cnt_w(CH_IN);
  localparam int unsigned XW   = cnt_w(OutX);
  localparam int unsigned YW   = cnt_w(OutY);

  state_e state_q, state_d;

  logic [KW-1:0] kx_q, ky_q;
  logic [CW-1:0] c_q;
  logic [XW-1:0] ox_q;
  logic [YW-1:0] oy_q;
  logic          relu_q;
  logic          rd_q;

  logic [PADDR_W-1:0] pa_q, pa_c;
  logic [WADDR_W-1:0] wa_q, wa_c;
  logic [OADDR_W-1:0] oa_q, oa_c;
  logic [OUT_W-1:0]   od_q, mac_result;
  logic [31:0]        pa_full, wa_full, oa_full;

  logic kx_last, ky_last, c_last, tap_last, ox_last, oy_last, out_last;
  logic accept, mac_clr;

  always_comb begin
    kx_last  = (kx_q == KW'(K - 1));
    ky_last  = (ky_q == KW'(K - 1));
    c_last   = (c_q == CW'(CH_IN - 1));
    tap_last = kx_last && ky_last && c_last;
    ox_last  = (ox_q == XW'(OutX - 1));
    oy_last  = (oy_q == YW'(OutY - 1));
    out_last = ox_last && oy_last;
    accept   = (state_q == StIdle) && start;
    mac_clr  = accept || (state_q == StWrite);

    pa_full = 32'(c_q) * 32'(IMG_W * IMG_H) + (32'(oy_q) + 32'(ky_q)) * 32'(IMG_W)
              + 32'(ox_q) + 32'(kx_q);
    wa_full = 32'(c_q) * 32'(K * K) + 32'(ky_q) * 32'(K) + 32'(kx_q);
    oa_full = 32'(oy_q) * 32'(OutX) + 32'(ox_q);
    pa_c    = pa_full[PADDR_W-1:0];
    wa_c    = wa_full[WADDR_W-1:0];
    oa_c    = oa_full[OADDR_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StFetch;
      StFetch: if (tap_last) state_d = StDrain;
      StDrain: state_d = StWrite;
      StWrite: state_d = out_last ? StDone : StFetch;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy        = (state_q == StFetch) || (state_q == StDrain) || (state_q == StWrite);
    finish      = (state_q == StDone);
    pixel_req   = (state_q == StFetch);
    weight_req  = (state_q == StFetch);
    output_req  = (state_q == StWrite);
    // Addresses and data are live in their active state and hold the last value otherwise.
    pixel_addr  = pixel_req ? pa_c : pa_q;
    weight_addr = weight_req ? wa_c : wa_q;
    output_addr = output_req ? oa_c : oa_q;
    output_data = output_req ? mac_result : od_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      rd_q    <= 1'b0;
      pa_q    <= '0;
      wa_q    <= '0;
      oa_q    <= '0;
      od_q    <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= pixel_req;
      if (pixel_req) begin
        pa_q <= pa_c;
        wa_q <= wa_c;
      end
      if (output_req) begin
        oa_q <= oa_c;
        od_q <= mac_result;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kx_q   <= '0;
      ky_q   <= '0;
      c_q    <= '0;
      ox_q   <= '0;
      oy_q   <= '0;
      relu_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            kx_q   <= '0;
            ky_q   <= '0;
            c_q    <= '0;
            ox_q   <= '0;
            oy_q   <= '0;
            relu_q <= relu_en;
          end
        end
        StFetch: begin
          if (kx_last) begin
            kx_q <= '0;
            if (ky_last) begin
              ky_q <= '0;
              c_q  <= c_last ? '0 : c_q + 1'b1;
            end else begin
              ky_q <= ky_q + 1'b1;
            end
          end else begin
            kx_q <= kx_q + 1'b1;
          end
        end
        StWrite: begin
          if (ox_last) begin
            ox_q <= '0;
            oy_q <= oy_last ? '0 : oy_q + 1'b1;
          end else begin
            ox_q <= ox_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  conv_mac #(
    .PIX_W(PIX_W),
    .WGT_W(WGT_W),
    .ACC_W(AccW),
    .OUT_W(OUT_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr),
    .en    (rd_q),
    .pixel (pixel),
    .weight(weight),
    .relu  (relu_q),
    .result(mac_result)
  );

endmodule
